// File: rtl/fft_bfly_stage_p.sv
// Radix-2 butterfly stage over LANES-wide blocks, DIST blocks apart; `define BFLY_ROUND_EN for round-half-up scaling.
// Latency: results registered 1 cycle after the accepting edge (sums live, diffs emitted on the following fill or drain).
// Backpressure: din_ready is low only while draining buffered diffs after flush; no output-side stall.
module fft_bfly_stage_p #(
    parameter int WIDTH = 9,
    parameter int LANES = 16,
    parameter int DIST  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] in_i [0:LANES-1],
    input  logic signed [WIDTH-1:0] in_q [0:LANES-1],
    input  logic                    din_valid,
    output logic                    din_ready,
    input  logic                    ifft,
    input  logic                    scale_en,
    input  logic                    flush,
    output logic signed [WIDTH:0]   dout_re [0:LANES-1],
    output logic signed [WIDTH:0]   dout_im [0:LANES-1],
    output logic                    dout_valid,
    output logic                    dout_diff
);

    localparam int CW = (DIST > 1) ? $clog2(DIST) : 1;

    typedef enum logic [1:0] {FILL, BFLY, DRAIN} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           pend, pend_nxt;
    logic           accept, last, emit, emit_diff, wr_en;

    logic signed [WIDTH:0] mem_re [0:DIST-1][0:LANES-1];
    logic signed [WIDTH:0] mem_im [0:DIST-1][0:LANES-1];

    logic signed [WIDTH:0] q_ext  [0:LANES-1];
    logic signed [WIDTH:0] b_re   [0:LANES-1];
    logic signed [WIDTH:0] b_im   [0:LANES-1];
    logic signed [WIDTH:0] sum_re [0:LANES-1];
    logic signed [WIDTH:0] sum_im [0:LANES-1];
    logic signed [WIDTH:0] dif_re [0:LANES-1];
    logic signed [WIDTH:0] dif_im [0:LANES-1];
    logic signed [WIDTH:0] out_re [0:LANES-1];
    logic signed [WIDTH:0] out_im [0:LANES-1];
    logic signed [WIDTH:0] wr_re  [0:LANES-1];
    logic signed [WIDTH:0] wr_im  [0:LANES-1];

    // Computed one bit wider than the stored word so rounding never wraps.
    function automatic logic signed [WIDTH:0] bfly_op(
        input logic signed [WIDTH:0] a,
        input logic signed [WIDTH:0] b,
        input logic                  sub,
        input logic                  sc
    );
        logic signed [WIDTH+1:0] v;
        v = sub ? ((WIDTH+2)'(a) - (WIDTH+2)'(b)) : ((WIDTH+2)'(a) + (WIDTH+2)'(b));
`ifdef BFLY_ROUND_EN
        if (sc) v = (v + (WIDTH+2)'(1)) >>> 1;
`else
        if (sc) v = v >>> 1;
`endif
        return v[WIDTH:0];
    endfunction

    assign din_ready = (state != DRAIN);
    assign accept    = din_valid && din_ready;
    assign last      = (cnt == CW'(DIST - 1));

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            q_ext[l]  = {in_q[l][WIDTH-1], in_q[l]};
            b_re[l]   = {in_i[l][WIDTH-1], in_i[l]};
            b_im[l]   = ifft ? -q_ext[l] : q_ext[l];
            sum_re[l] = bfly_op(mem_re[cnt][l], b_re[l], 1'b0, scale_en);
            sum_im[l] = bfly_op(mem_im[cnt][l], b_im[l], 1'b0, scale_en);
            dif_re[l] = bfly_op(mem_re[cnt][l], b_re[l], 1'b1, scale_en);
            dif_im[l] = bfly_op(mem_im[cnt][l], b_im[l], 1'b1, scale_en);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_nxt  = pend;
        emit      = 1'b0;
        emit_diff = 1'b0;
        wr_en     = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            out_re[l] = sum_re[l];
            out_im[l] = sum_im[l];
            wr_re[l]  = b_re[l];
            wr_im[l]  = b_im[l];
        end
        case (state)
            FILL: begin
                if (accept) begin
                    wr_en     = 1'b1;
                    emit      = pend;
                    emit_diff = pend;
                    for (int l = 0; l < LANES; l++) begin
                        out_re[l] = mem_re[cnt][l];
                        out_im[l] = mem_im[cnt][l];
                    end
                    cnt_nxt = last ? '0 : cnt + CW'(1);
                    if (last) begin
                        state_nxt = BFLY;
                        pend_nxt  = 1'b0;
                    end
                end else if (pend && cnt == '0 && flush) begin
                    state_nxt = DRAIN;
                end
            end
            BFLY: begin
                if (accept) begin
                    wr_en = 1'b1;
                    emit  = 1'b1;
                    for (int l = 0; l < LANES; l++) begin
                        wr_re[l] = dif_re[l];
                        wr_im[l] = dif_im[l];
                    end
                    cnt_nxt = last ? '0 : cnt + CW'(1);
                    if (last) begin
                        state_nxt = FILL;
                        pend_nxt  = 1'b1;
                    end
                end
            end
            DRAIN: begin
                emit      = 1'b1;
                emit_diff = 1'b1;
                for (int l = 0; l < LANES; l++) begin
                    out_re[l] = mem_re[cnt][l];
                    out_im[l] = mem_im[cnt][l];
                end
                cnt_nxt = last ? '0 : cnt + CW'(1);
                if (last) begin
                    state_nxt = FILL;
                    pend_nxt  = 1'b0;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            cnt        <= '0;
            pend       <= 1'b0;
            dout_valid <= 1'b0;
            dout_diff  <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                dout_re[l] <= '0;
                dout_im[l] <= '0;
            end
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            pend       <= pend_nxt;
            dout_valid <= emit;
            if (emit) begin
                dout_diff <= emit_diff;
                for (int l = 0; l < LANES; l++) begin
                    dout_re[l] <= out_re[l];
                    dout_im[l] <= out_im[l];
                end
            end
        end
    end

    // Buffer contents are don't-care after reset: pend=0 guarantees a refill before any read-out.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int l = 0; l < LANES; l++) begin
                mem_re[cnt][l] <= wr_re[l];
                mem_im[cnt][l] <= wr_im[l];
            end
        end
    end

endmodule

// File: tb/tb_fft_bfly_stage_p.sv
// Directed-vector bench for fft_bfly_stage_p at WIDTH=9, LANES=16, DIST=4.
module tb_fft_bfly_stage_p;
    localparam int WIDTH = 9;
    localparam int LANES = 16;
    localparam int DIST  = 4;

`ifdef BFLY_ROUND_EN
    localparam int S_POS3 = 2;
    localparam int S_NEG3 = -1;
`else
    localparam int S_POS3 = 1;
    localparam int S_NEG3 = -2;
`endif

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic signed [WIDTH-1:0] in_i [0:LANES-1];
    logic signed [WIDTH-1:0] in_q [0:LANES-1];
    logic                    din_valid = 1'b0;
    logic                    din_ready;
    logic                    ifft = 1'b0;
    logic                    scale_en = 1'b0;
    logic                    flush = 1'b0;
    logic signed [WIDTH:0]   dout_re [0:LANES-1];
    logic signed [WIDTH:0]   dout_im [0:LANES-1];
    logic                    dout_valid;
    logic                    dout_diff;

    int checks = 0;
    int errors = 0;

    fft_bfly_stage_p #(.WIDTH(WIDTH), .LANES(LANES), .DIST(DIST)) dut (
        .clk(clk), .rst(rst), .in_i(in_i), .in_q(in_q),
        .din_valid(din_valid), .din_ready(din_ready), .ifft(ifft),
        .scale_en(scale_en), .flush(flush), .dout_re(dout_re), .dout_im(dout_im),
        .dout_valid(dout_valid), .dout_diff(dout_diff)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus (all lanes identical), then step past the edge.
    task automatic drive(input bit v, input int re, input int im, input bit sc,
                         input bit cj, input bit fl);
        din_valid = v;
        scale_en  = sc;
        ifft      = cj;
        flush     = fl;
        for (int l = 0; l < LANES; l++) begin
            in_i[l] = WIDTH'(re);
            in_q[l] = WIDTH'(im);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic blk(input int re, input int im = 0, input bit sc = 0, input bit cj = 0);
        drive(1'b1, re, im, sc, cj, 1'b0);
    endtask

    task automatic exp_none(input string tag);
        check({tag, ".valid"}, int'(dout_valid), 0);
    endtask

    task automatic exp_blk(input string tag, input int diff, input int re, input int im);
        check({tag, ".valid"}, int'(dout_valid), 1);
        check({tag, ".diff"},  int'(dout_diff), diff);
        check({tag, ".re0"},   int'(dout_re[0]), re);
        check({tag, ".re15"},  int'(dout_re[LANES-1]), re);
        check({tag, ".im0"},   int'(dout_im[0]), im);
        check({tag, ".im15"},  int'(dout_im[LANES-1]), im);
    endtask

    initial begin
        for (int l = 0; l < LANES; l++) begin
            in_i[l] = '0;
            in_q[l] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", int'(dout_valid), 0);
        check("rst.ready", int'(din_ready), 1);
        check("rst.diff",  int'(dout_diff), 0);
        check("rst.re0",   int'(dout_re[0]), 0);
        rst = 1'b0;

        // Basic butterfly: fill 1..4, partners 5..8, then zero blocks flush out diffs.
        for (int k = 1; k <= 4; k++) begin
            blk(k);
            exp_none("fill");
        end
        for (int k = 5; k <= 8; k++) begin
            blk(k);
            exp_blk("sum", 0, 2 * k - 4, 0);
        end
        for (int k = 0; k < 4; k++) begin
            blk(0);
            exp_blk("dif", 1, -4, 0);
        end
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        exp_none("idle");
        check("idle.hold_re", int'(dout_re[0]), -4);

        for (int k = 0; k < 4; k++) blk(0);
        exp_blk("zsum", 0, 0, 0);

        // Extremes and positive scaling.
        blk(255);  exp_blk("ext.d0", 1, 0, 0);
        blk(-256);
        blk(255);
        blk(3);
        blk(255);       exp_blk("ext.sum_max", 0, 510, 0);
        blk(-256);      exp_blk("ext.sum_min", 0, -512, 0);
        blk(-256);      exp_blk("ext.sum_mix", 0, -1, 0);
        blk(0, 0, 1);   exp_blk("scl.pos", 0, S_POS3, 0);

        // Diffs out; load -3, a conjugated partner and two ones.
        blk(-3);        exp_blk("ext.dif0", 1, 0, 0);
        blk(0, 5, 0, 1);
        blk(1);         exp_blk("ext.dif_max", 1, 511, 0);
        blk(1);         exp_blk("scl.pos_dif", 1, S_POS3, 0);

        blk(0, 0, 1);   exp_blk("scl.neg", 0, S_NEG3, 0);
        blk(0, 5, 0, 1); exp_blk("ifft.sum", 0, 0, -10);
        blk(1);         exp_blk("b31", 0, 2, 0);
        blk(0);         exp_blk("b32", 0, 1, 0);

        // Drain with flush while idle.
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        check("drn.entry_ready", int'(din_ready), 0);
        exp_none("drn.entry");
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        exp_blk("drn0", 1, S_NEG3, 0);
        check("drn0.ready", int'(din_ready), 0);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        exp_blk("drn1", 1, 0, 0);
        check("drn1.ready", int'(din_ready), 0);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        exp_blk("drn2", 1, 0, 0);
        check("drn2.ready", int'(din_ready), 0);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        exp_blk("drn3", 1, 1, 0);
        check("drn3.ready", int'(din_ready), 1);

        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        check("fl_nopend.ready", int'(din_ready), 1);
        exp_none("fl_nopend");

        for (int k = 0; k < 4; k++) blk(2);
        exp_none("refill");
        for (int k = 0; k < 4; k++) blk(1);
        exp_blk("rsum", 0, 3, 0);

        // Flush together with a valid block: the block wins.
        drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1);
        exp_blk("fl_acc", 1, 1, 0);
        check("fl_acc.ready", int'(din_ready), 1);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        check("fl_cnt1.ready", int'(din_ready), 1);
        exp_none("fl_cnt1");
        flush = 1'b0;
        for (int k = 0; k < 3; k++) blk(0);
        exp_blk("rdif", 1, 1, 0);
        blk(5);         exp_blk("pre_rst", 0, 5, 0);

        // Asynchronous reset mid-BFLY.
        din_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst.valid", int'(dout_valid), 0);
        check("arst.re0",   int'(dout_re[0]), 0);
        check("arst.re15",  int'(dout_re[LANES-1]), 0);
        check("arst.ready", int'(din_ready), 1);
        check("arst.diff",  int'(dout_diff), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int k = 0; k < 4; k++) begin
            blk(3);
            exp_none("post_fill");
        end
        blk(4);         exp_blk("post_sum", 0, 7, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
